led_bank_arbiter: RTL and testbench



---
 rtl/led_bank_arbiter.sv | 88 ++++++++
 tb/tb_led_bank_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin owner of the LED bank with min/max dwell in prescaler ticks.
// Define LED_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module led_bank_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int PRESC_W   = 24,
    parameter int MIN_TICKS = 2,
    parameter int MAX_TICKS = 8
) (
    input  logic                   clk50,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [6*NUM_REQ-1:0]   pattern,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [5:0]             leds,
    output logic                   blink,
    output logic                   tick
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    localparam int OW = $clog2(NUM_REQ);
    localparam int DW = $clog2(MAX_TICKS + 1);
    localparam logic [DW-1:0] MIN_D = DW'(MIN_TICKS);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_TICKS);
    state_t               state;
    logic [PRESC_W-1:0]   presc;
    logic [DW-1:0]        dwell;
    logic [OW-1:0]        owner, pick;
    logic [NUM_REQ-1:0]   rivals;
    logic [5:0]           pats [NUM_REQ];
    logic                 release_now;
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) pats[i] = pattern[6*i +: 6];
    end
    // owner doubles as the round-robin pointer: it always holds the last granted index
    always_comb begin
        pick = '0;
`ifdef LED_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) pick = OW'(i);
        rivals = req & (gnt - NUM_REQ'(1));
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i] && OW'(i) <= owner) pick = OW'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i] && OW'(i) > owner) pick = OW'(i);
        rivals = req & ~gnt;
`endif
        release_now = (dwell >= MIN_D && !req[owner]) || (dwell >= MAX_D && |rivals);
    end
    always_ff @(posedge clk50) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
            tick  <= 1'b0;
            blink <= 1'b0;
            dwell <= '0;
            owner <= OW'(NUM_REQ - 1);
            gnt   <= '0;
            leds  <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
            tick  <= &presc;
            blink <= blink ^ tick;
            case (state)
                IDLE: begin
                    leds <= '0;
                    if (|req) begin
                        owner <= pick;
                        gnt   <= NUM_REQ'(1) << pick;
                        dwell <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt   <= '0;
                        leds  <= '0;
                        state <= GAP;
                    end else begin
                        leds <= pats[owner];
                        if (tick && dwell != MAX_D) dwell <= dwell + DW'(1);
                    end
                end
                default: begin
                    gnt   <= '0;
                    leds  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: directed and randomized checks against a cycle-level reference model.
module tb_led_bank_arbiter;
    logic        clk50 = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [17:0] pattern;
    logic [2:0]  gnt;
    logic [5:0]  leds;
    logic        blink, tick;
    int tests = 0, fails = 0;
    int n, m_mode, m_own, m_last, m_dw, idx;
    logic [2:0] exp_gnt, prev_obs, last_g;
    logic [5:0] exp_leds;
    logic exp_tick, exp_blink, tick_now, hit, have_prev;

    led_bank_arbiter #(.NUM_REQ(3), .PRESC_W(4), .MIN_TICKS(2), .MAX_TICKS(4)) dut (
        .clk50(clk50), .rst(rst), .req(req), .pattern(pattern),
        .gnt(gnt), .leds(leds), .blink(blink), .tick(tick)
    );

    always #5 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [5:0] pat(input int i);
        return 6'(pattern >> (6 * i));
    endfunction

    // Model: n = edges since reset; tick after every 16th edge; blink counts ticks mod 2.
    task automatic step();
        @(posedge clk50);
        if (rst) begin
            n = 0; m_mode = 0; m_last = 2; m_dw = 0;
            exp_gnt = 3'b000; exp_leds = 6'h00;
        end else begin
            tick_now = (n > 0 && n % 16 == 0);
            if (m_mode == 1) begin
                if ((m_dw >= 2 && !req[m_own]) || (m_dw >= 4 && (req & ~exp_gnt) != 3'b000)) begin
                    exp_gnt = 3'b000; exp_leds = 6'h00; m_mode = 2;
                end else begin
                    exp_leds = pat(m_own);
                    if (tick_now && m_dw < 4) m_dw++;
                end
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else begin
                exp_leds = 6'h00;
                hit = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    idx = (m_last + k) % 3;
                    if (!hit && req[idx]) begin
                        hit = 1'b1; m_own = idx; m_last = idx;
                    end
                end
                if (hit) begin
                    exp_gnt = 3'(1 << m_own); m_dw = 0; m_mode = 1;
                end
            end
            n++;
        end
        exp_tick  = (n > 0 && n % 16 == 0);
        exp_blink = (n == 0) ? 1'b0 : 1'(((n - 1) / 16) % 2);
        #1;
        chk("gnt", gnt, exp_gnt);
        chk("leds", leds, exp_leds);
        chk("tick", tick, exp_tick);
        chk("blink", blink, exp_blink);
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; pattern = 18'h0;
        step(); step();
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_blink", blink, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) step();
        req = 3'b010; pattern = 18'h00A80;
        step();
        chk("first_gnt", gnt, 3'b010);
        chk("first_leds_lag", leds, 6'h00);
        step();
        chk("first_leds", leds, 6'h2A);
        for (int i = 0; i < 100 && m_dw < 2; i++) step();
        req = 3'b000;
        step();
        chk("drop_gnt", gnt, 3'b000);
        chk("drop_leds", leds, 6'h00);
        step(); step();
        req = 3'b010;
        step();
        req = 3'b000;
        for (int i = 0; i < 10; i++) step();
        chk("min_hold", gnt, 3'b010);
        for (int i = 0; i < 50; i++) step();
        req = 3'b111; have_prev = 1'b0; prev_obs = gnt;
        for (int i = 0; i < 400; i++) begin
            pattern = 18'($urandom);
            step();
            if (gnt !== 3'b000 && prev_obs === 3'b000) begin
                if (have_prev) chk("rr_order", gnt, {last_g[1:0], last_g[2]});
                last_g = gnt; have_prev = 1'b1;
            end
            prev_obs = gnt;
        end
        req = 3'b000;
        for (int i = 0; i < 5; i++) step();
        req = 3'b001;
        for (int i = 0; i < 100; i++) step();
        chk("no_revoke", gnt, 3'b001);
        req = 3'b101;
        step();
        chk("revoke_gnt", gnt, 3'b000);
        step(); step();
        chk("revoke_next", gnt, 3'b100);
        req = 3'b010; pattern = 18'h3FFFF;
        for (int i = 0; i < 200 && exp_leds != 6'h3F; i++) step();
        chk("pre_rst_leds", leds, 6'h3F);
        rst = 1'b1;
        step();
        chk("mid_rst_leds", leds, 6'h00);
        chk("mid_rst_gnt", gnt, 3'b000);
        chk("mid_rst_blink", blink, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(23) == 0) req[b] = ~req[b];
            pattern = 18'($urandom);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
